// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a per-owner hold limit and a one-cycle
// bubble between owners.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_busy;
  logic               r_timeout;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_hold_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_busy_nxt;
  logic               w_timeout_nxt;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_cand;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Winner search from ptr upward, then next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_gnt_idx;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_found       = 1'b0;
    w_win         = '0;
    w_cand        = '0;

    for (int k = 0; k < N_REQ; k++) begin
      w_cand = r_ptr + IDX_W'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_hold_nxt = '0;
        if (en && w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = N_REQ'(1) << w_win;
          w_idx_nxt   = w_win;
          w_busy_nxt  = 1'b1;
        end
      end
      S_GRANT: begin
        if (!en || !req[r_gnt_idx] || (r_hold_cnt == HOLD_LAST)) begin
          // Disable and request drop take priority over the hold limit
          w_state_nxt   = S_IDLE;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_hold_nxt    = '0;
          w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
          w_timeout_nxt = en && req[r_gnt_idx];
        end else begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: expected outputs are queued with each
// stimulus step and popped for comparison after the clock edge.
module tb_rr_arbiter4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int   checks;
  int   errors;
  int   step_no;
  logic armed;
  exp_t sb[$];
  int   owners[5] = '{0, 1, 2, 3, 0};

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int o);
    logic [3:0] one;
    one = 4'b0001;
    return one << o;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, check after the edge
  task automatic step(input logic r, input logic e, input logic [3:0] q,
                      input logic [3:0] eg, input logic [1:0] ei,
                      input logic eb, input logic et);
    exp_t x;
    exp_t o;
    rst = r;
    en  = e;
    req = q;
    x.gnt  = eg;
    x.idx  = ei;
    x.busy = eb;
    x.to   = et;
    sb.push_back(x);
    @(posedge clk);
    #1;
    step_no++;
    o = sb.pop_front();
    chk("gnt",     8'(gnt),     8'(o.gnt));
    chk("gnt_idx", 8'(gnt_idx), 8'(o.idx));
    chk("busy",    8'(busy),    8'(o.busy));
    chk("timeout", 8'(timeout), 8'(o.to));
  endtask

  // Structural invariants sampled on every falling edge
  always @(negedge clk) begin
    if (armed) begin
      chk("onehot", 8'($onehot0(gnt)), 8'd1);
      chk("busy_or", 8'(busy), 8'(|gnt));
      if (busy) chk("idx_decode", 8'(gnt), 8'(oh(int'(gnt_idx))));
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    armed   = 1'b0;
    rst = 1'b1; en = 1'b0; req = 4'b0000;

    // Reset, including reset overriding active requests
    step(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    armed = 1'b1;
    step(1, 1, 4'b1111, 4'b0000, 2'd0, 0, 0);

    // First grant searches from 0: req 1010 -> owner 1
    step(0, 1, 4'b1010, 4'b0010, 2'd1, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 0);
    step(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // All requesting: rotate 0,1,2,3,0 with 8-cycle holds and timeouts
    foreach (owners[n]) begin
      for (int c = 0; c < 8; c++)
        step(0, 1, 4'b1111, oh(owners[n]), 2'(owners[n]), 1, 0);
      step(0, 1, 4'b1111, 4'b0000, 2'(owners[n]), 0, 1);
    end
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // Owner 2 drops after 3 cycles, requester 0 waits through the bubble
    for (int c = 0; c < 3; c++)
      step(0, 1, 4'b0101, 4'b0100, 2'd2, 1, 0);
    step(0, 1, 4'b0001, 4'b0000, 2'd2, 0, 0);
    step(0, 1, 4'b0001, 4'b0001, 2'd0, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // en dropped mid-grant; afterwards 2/3/0 are searched before 1
    step(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    step(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    step(0, 0, 4'b0010, 4'b0000, 2'd1, 0, 0);
    step(0, 0, 4'b1011, 4'b0000, 2'd1, 0, 0);
    step(0, 0, 4'b1011, 4'b0000, 2'd1, 0, 0);
    step(0, 1, 4'b1011, 4'b1000, 2'd3, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd3, 0, 0);

    // Reset while owner 3 holds, then regrant; then ptr wraps 3 -> 0
    step(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 0);
    step(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 4'b1000, 4'b0000, 2'd0, 0, 0);
    step(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd3, 0, 0);
    step(0, 1, 4'b1001, 4'b0001, 2'd0, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // Sole requester 1: timeout, bubble, regrant; en drop at limit gives no timeout
    for (int c = 0; c < 8; c++)
      step(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    step(0, 1, 4'b0010, 4'b0000, 2'd1, 0, 1);
    for (int c = 0; c < 8; c++)
      step(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    step(0, 0, 4'b0010, 4'b0000, 2'd1, 0, 0);

    // Timed-out owner 0 yields to active requester 1
    for (int c = 0; c < 8; c++)
      step(0, 1, 4'b0011, 4'b0001, 2'd0, 1, 0);
    step(0, 1, 4'b0011, 4'b0000, 2'd0, 0, 1);
    step(0, 1, 4'b0011, 4'b0010, 2'd1, 1, 0);
    step(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 0);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
